seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, clocked successor to the combinational datapath ALU. It keeps the same 5-bit opcode encoding for the single-cycle operations and registers every result. It adds multi-cycle unsigned multiply (full double-width product) and unsigned divide/remainder using an iterative shift-add or shift-subtract engine with a start/busy/done handshake. It sits in the EX stage; the pipeline control stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (>=4, even)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only when busy=0
control  input  5  opcode, sampled with start
A  input  WIDTH  operand A, sampled with start
B  input  WIDTH  operand B, sampled with start
out  output  WIDTH  primary result (low product / quotient / ALU result)
hi  output  WIDTH  secondary result (high product / remainder); 0 for single-cycle ops
done  output  1  one-cycle pulse: out/hi/flags valid for the accepted op
busy  output  1  1 while a multi-cycle op is iterating; start ignored
div_zero  output  1  with done: last op was DIV and B==0
illegal  output  1  with done: last opcode was unsupported

Behaviour:
- Reset: state IDLE; out, hi, done, busy, div_zero, illegal, counter and internal registers all 0. Reset wins over start in the same cycle. Reset mid-iteration aborts silently with no done.
- States: IDLE, RUN. DONE is a registered pulse, not a state.
- Accept: at an edge with start=1 and busy=0, control, A and B are captured.
- Single-cycle ops (latency 1; done=1 in the cycle after the accept edge):
  - 00000 ADD: out=A+B mod 2^WIDTH
  - 00001 SUB: out=A-B mod 2^WIDTH
  - 00010 AND: out=A&B
  - 00011 OR: out=A|B
  - 00100 SLT: out=1 if A<B unsigned, else 0
  - 00110 SLTS: out=1 if A<B two's-complement, else 0
  - For all of these, hi=0.
- Multi-cycle ops (IDLE->RUN at the accept edge; busy=1 from the next cycle):
  - 00101 MUL: unsigned; {hi,out}=A*B (2*WIDTH bits). The low half equals the legacy MUL result.
  - 00111 DIV: unsigned restoring division; out=A/B, hi=A%B.
  - Exactly WIDTH iterations, one per edge. After the WIDTH-th iteration edge: RUN->IDLE, busy=0, done=1. Total latency is WIDTH+1 edges from the accept edge.
- DIV with B==0: no iteration; behaves as a single-cycle op (latency 1). out = all ones, hi=A, div_zero=1.
- Unsupported opcode (01000..11111): latency 1, out=0, hi=0, illegal=1.
- done, div_zero and illegal are 1 for exactly one cycle per completed op, otherwise 0.
- out and hi hold their last value until the next completion. They are not updated during RUN; internal accumulators are separate.
- Back-to-back: start may be high in the done cycle and is accepted (busy=0). Consecutive single-cycle ops therefore give done=1 on consecutive cycles.
- start while busy=1: ignored, not queued. Inputs changing during RUN have no effect.

Test Plan:
- WIDTH=32; reset, then start ADD A=0xFFFFFFFF B=2 -> next cycle done=1, out=0x00000001, hi=0, flags 0.
- SLT vs SLTS with A=0xFFFFFFFF, B=1 -> SLT out=0, SLTS out=1; issued back-to-back, done high on two consecutive cycles.
- MUL A=0xFFFFFFFF B=0xFFFFFFFF -> busy for 32 cycles; done exactly 33 edges after accept; out=0x00000001, hi=0xFFFFFFFE. A start pulse during busy is ignored (single done).
- DIV A=100 B=7 -> done at 33 edges, out=14, hi=2. Then DIV A=5 B=0 -> 1-cycle latency, out=0xFFFFFFFF, hi=5, div_zero=1.
- Opcode 11111 A=3 B=4 -> next cycle done=1, illegal=1, out=0, hi=0.
- Start MUL, assert rst at iteration 10 -> busy=0, out=0, hi=0, no done pulse. A subsequent ADD 2+3 yields out=5 with latency 1. Repeat with WIDTH=8: MUL 0xFF*0xFF -> done at 9 edges, hi=0xFE, out=0x01.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered single-cycle ALU plus an iterative unsigned multiply
// (shift-add) and restoring divide (shift-subtract) behind start/busy/done.
module seq_alu #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       control,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] hi,
   output logic             done,
   output logic             busy,
   output logic             div_zero,
   output logic             illegal
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_SLT  = 5'b00100;
   localparam logic [4:0] OP_MUL  = 5'b00101;
   localparam logic [4:0] OP_SLTS = 5'b00110;
   localparam logic [4:0] OP_DIV  = 5'b00111;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] shr_q, shr_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] fast_out, fast_hi;
   logic             fast_dz, fast_il;
   logic             go_multi;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_acc, mul_shr;
   logic [WIDTH:0]   div_rem;
   logic             div_ge;
   logic [WIDTH-1:0] div_acc, div_shr;
   logic [WIDTH-1:0] step_acc, step_shr;

   // Results of the latency-1 operations, including the divide-by-zero and
   // illegal-opcode outcomes.
   always_comb begin
      fast_out = '0;
      fast_hi  = '0;
      fast_dz  = 1'b0;
      fast_il  = 1'b0;
      case (control)
         OP_ADD:  fast_out = A + B;
         OP_SUB:  fast_out = A - B;
         OP_AND:  fast_out = A & B;
         OP_OR:   fast_out = A | B;
         OP_SLT:  fast_out = {{(WIDTH-1){1'b0}}, A < B};
         OP_SLTS: fast_out = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         OP_MUL:  fast_out = '0;
         OP_DIV: begin
            fast_out = '1;
            fast_hi  = A;
            fast_dz  = 1'b1;
         end
         default: fast_il = 1'b1;
      endcase
   end

   assign go_multi = (control == OP_MUL) || ((control == OP_DIV) && (B != '0));

   // Multiply step: {acc, shr} holds the partial product, multiplier in shr.
   always_comb begin
      mul_sum = {1'b0, acc_q} + ({(WIDTH+1){shr_q[0]}} & {1'b0, opb_q});
      mul_acc = mul_sum[WIDTH:1];
      mul_shr = {mul_sum[0], shr_q[WIDTH-1:1]};
   end

   // Divide step: acc is the partial remainder, shr shifts dividend out and
   // quotient bits in. The W-bit subtraction is exact because the true
   // difference is below the divisor whenever it is taken.
   always_comb begin
      div_rem = {acc_q, shr_q[WIDTH-1]};
      div_ge  = div_rem >= {1'b0, opb_q};
      div_acc = div_ge ? (div_rem[WIDTH-1:0] - opb_q) : div_rem[WIDTH-1:0];
      div_shr = {shr_q[WIDTH-2:0], div_ge};
   end

   assign step_acc = is_div_q ? div_acc : mul_acc;
   assign step_shr = is_div_q ? div_shr : mul_shr;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_div_d   = is_div_q;
      acc_d      = acc_q;
      shr_d      = shr_q;
      opb_d      = opb_q;
      out_d      = out_q;
      hi_d       = hi_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      illegal_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (go_multi) begin
                  state_d  = RUN;
                  cnt_d    = '0;
                  is_div_d = (control == OP_DIV);
                  acc_d    = '0;
                  shr_d    = A;
                  opb_d    = B;
               end else begin
                  out_d      = fast_out;
                  hi_d       = fast_hi;
                  done_d     = 1'b1;
                  div_zero_d = fast_dz;
                  illegal_d  = fast_il;
               end
            end
         end
         RUN: begin
            acc_d = step_acc;
            shr_d = step_shr;
            if (cnt_q == LAST_ITER) begin
               state_d = IDLE;
               cnt_d   = '0;
               out_d   = step_shr;
               hi_d    = step_acc;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         acc_q      <= '0;
         shr_q      <= '0;
         opb_q      <= '0;
         out_q      <= '0;
         hi_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_div_q   <= is_div_d;
         acc_q      <= acc_d;
         shr_q      <= shr_d;
         opb_q      <= opb_d;
         out_q      <= out_d;
         hi_q       <= hi_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         illegal_q  <= illegal_d;
      end
   end

   assign out      = out_q;
   assign hi       = hi_q;
   assign done     = done_q;
   assign busy     = (state_q == RUN);
   assign div_zero = div_zero_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu at WIDTH=32 and WIDTH=8 against
// an arithmetic reference model.
module tb_seq_alu;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, use8;
   logic [4:0]  control;
   logic [31:0] a, b;

   logic        start32, start8;
   logic [31:0] out32, hi32;
   logic        done32, busy32, dz32, il32;
   logic [7:0]  out8, hi8;
   logic        done8, busy8, dz8, il8;

   logic [31:0] r_out, r_hi;
   logic        r_done, r_busy, r_dz, r_il;

   int n_checks = 0;
   int n_pass   = 0;

   assign start32 = start & ~use8;
   assign start8  = start & use8;

   seq_alu #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start32), .control(control), .A(a), .B(b),
      .out(out32), .hi(hi32), .done(done32), .busy(busy32), .div_zero(dz32),
      .illegal(il32)
   );

   seq_alu #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .control(control), .A(a[7:0]), .B(b[7:0]),
      .out(out8), .hi(hi8), .done(done8), .busy(busy8), .div_zero(dz8),
      .illegal(il8)
   );

   assign r_out  = use8 ? {24'd0, out8} : out32;
   assign r_hi   = use8 ? {24'd0, hi8} : hi32;
   assign r_done = use8 ? done8 : done32;
   assign r_busy = use8 ? busy8 : busy32;
   assign r_dz   = use8 ? dz8 : dz32;
   assign r_il   = use8 ? il8 : il32;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reference: results straight from the arithmetic definition of each op.
   function automatic void model(input int w, input logic [4:0] op,
                                 input logic [31:0] a_in, input logic [31:0] b_in,
                                 output logic [31:0] o, output logic [31:0] h,
                                 output bit dz, output bit il, output int lat);
      logic [63:0] m, pa, pb, p;
      longint sa, sb;
      m  = (64'd1 << w) - 64'd1;
      pa = {32'd0, a_in} & m;
      pb = {32'd0, b_in} & m;
      sa = pa[w-1] ? longint'(pa) - longint'(64'd1 << w) : longint'(pa);
      sb = pb[w-1] ? longint'(pb) - longint'(64'd1 << w) : longint'(pb);
      o = '0; h = '0; dz = 0; il = 0; lat = 1;
      case (op)
         5'd0: p = (pa + pb) & m;
         5'd1: p = (pa - pb) & m;
         5'd2: p = pa & pb;
         5'd3: p = pa | pb;
         5'd4: p = (pa < pb) ? 64'd1 : 64'd0;
         5'd6: p = (sa < sb) ? 64'd1 : 64'd0;
         5'd5: begin
            p   = pa * pb;
            h   = 32'((p >> w) & m);
            p   = p & m;
            lat = w + 1;
         end
         5'd7: begin
            if (pb == 0) begin
               p  = m;
               h  = pa[31:0];
               dz = 1;
            end else begin
               p   = pa / pb;
               h   = 32'(pa % pb);
               lat = w + 1;
            end
         end
         default: begin
            p  = 64'd0;
            il = 1;
         end
      endcase
      o = p[31:0];
   endfunction

   task automatic run_op(input logic [4:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input bit poke);
      int w, k, exp_lat;
      logic [31:0] eo, eh;
      bit edz, eil;
      w = use8 ? 8 : 32;
      model(w, op, aa, bb, eo, eh, edz, eil, exp_lat);
      @(negedge clk);
      control = op; a = aa; b = bb; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = $urandom; b = $urandom; control = 5'($urandom);
      k = 1;
      check("busy_after_accept", 64'(r_busy), 64'(exp_lat > 1));
      while (!r_done && k < 2 * w + 8) begin
         if (poke && k == 5) begin
            start = 1'b1;
            control = 5'd0;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         k++;
      end
      check("latency", 64'(k), 64'(exp_lat));
      check("out", 64'(r_out), 64'(eo));
      check("hi", 64'(r_hi), 64'(eh));
      check("div_zero", 64'(r_dz), 64'(edz));
      check("illegal", 64'(r_il), 64'(eil));
      check("busy_at_done", 64'(r_busy), 64'(0));
      @(posedge clk);
      #1;
      check("done_pulse", 64'(r_done), 64'(0));
      check("flags_pulse", 64'({r_dz, r_il}), 64'(0));
      check("out_hold", 64'(r_out), 64'(eo));
      check("hi_hold", 64'(r_hi), 64'(eh));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      logic [4:0]  op;
      logic [31:0] ra, rb;

      use8 = 1'b0;
      rst = 1'b1; start = 1'b1; control = 5'd0; a = 32'd1; b = 32'd1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", 64'(r_out), 64'(0));
      check("rst_hi", 64'(r_hi), 64'(0));
      check("rst_done", 64'(r_done), 64'(0));
      check("rst_busy", 64'(r_busy), 64'(0));
      check("rst_flags", 64'({r_dz, r_il}), 64'(0));
      @(negedge clk);
      rst = 1'b0; start = 1'b0;

      run_op(5'd0, 32'hFFFF_FFFF, 32'd2, 0);
      run_op(5'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      run_op(5'd7, 32'd100, 32'd7, 0);
      run_op(5'd7, 32'd5, 32'd0, 0);
      run_op(5'b11111, 32'd3, 32'd4, 0);

      // SLT then SLTS back to back
      @(negedge clk);
      start = 1'b1; control = 5'd4; a = 32'hFFFF_FFFF; b = 32'd1;
      @(posedge clk);
      #1;
      control = 5'd6;
      check("b2b_slt_done", 64'(r_done), 64'(1));
      check("b2b_slt_out", 64'(r_out), 64'(0));
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_slts_done", 64'(r_done), 64'(1));
      check("b2b_slts_out", 64'(r_out), 64'(1));

      // Reset in the middle of a multiply aborts it
      @(negedge clk);
      start = 1'b1; control = 5'd5; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 64'(r_busy), 64'(0));
      check("abort_out", 64'(r_out), 64'(0));
      check("abort_hi", 64'(r_hi), 64'(0));
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (r_done) seen = 1;
      end
      check("abort_no_done", 64'(seen), 64'(0));
      run_op(5'd0, 32'd2, 32'd3, 0);

      for (int i = 0; i < 150; i++) begin
         op = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 31));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
         run_op(op, ra, rb, $urandom_range(0, 3) == 0);
      end

      use8 = 1'b1;
      run_op(5'd5, 32'hFF, 32'hFF, 0);
      run_op(5'd7, 32'd200, 32'd9, 0);
      for (int i = 0; i < 80; i++) begin
         op = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(8, 31));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         run_op(op, ra, rb, $urandom_range(0, 3) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
